qkv_token_buffer: RTL and testbench

Token-serial input buffer that sits directly upstream of the Q·K^T stage. It accepts one token per handshake: the Q, K and V row vectors of one token. It assembles TOKEN_NUM tokens into full Q, K and V matrices in a ping-pong (two-bank) store, then presents a complete frame on flattened matrix buses with a valid/ready handshake. While one bank is consumed downstream, the other bank fills, so a new token is accepted every cycle.

---
 rtl/qkv_token_buffer.sv | 124 ++++++++++++
 tb/tb_qkv_token_buffer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/qkv_token_buffer.sv
// qkv_token_buffer
//
// Token-serial ping-pong buffer in front of the Q*K^T stage. Each accepted
// token carries one row of Q, K and V. TOKEN_NUM rows fill one bank. A filled
// bank is presented as complete flattened matrices while the other bank keeps
// filling, so one token per cycle can be sustained.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready.
// The sender holds valid and its data steady until that edge. in_ready never
// depends on in_valid, and out_valid never depends on out_ready.
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   flush               synchronous discard of the partially written frame
//   in_valid/in_ready   token handshake for q_tok/k_tok/v_tok
//   q_tok, k_tok, v_tok one token row, element j at [DW*(j+1)-1 : DW*j]
//   out_valid/out_ready frame handshake for Q_out/K_out/V_out
//   Q_out, K_out, V_out row-major matrices, token i in row slice i
//   fill_level          tokens held in the current write bank
module qkv_token_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int TOKEN_DIM  = 4,
  parameter int TOKEN_NUM  = 8
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         flush,
  input  logic                                         in_valid,
  output logic                                         in_ready,
  input  logic [DATA_WIDTH*TOKEN_DIM-1:0]              q_tok,
  input  logic [DATA_WIDTH*TOKEN_DIM-1:0]              k_tok,
  input  logic [DATA_WIDTH*TOKEN_DIM-1:0]              v_tok,
  output logic                                         out_valid,
  input  logic                                         out_ready,
  output logic [DATA_WIDTH*TOKEN_DIM*TOKEN_NUM-1:0]    Q_out,
  output logic [DATA_WIDTH*TOKEN_DIM*TOKEN_NUM-1:0]    K_out,
  output logic [DATA_WIDTH*TOKEN_DIM*TOKEN_NUM-1:0]    V_out,
  output logic [$clog2(TOKEN_NUM+1)-1:0]               fill_level
);

  localparam int ROW_W = DATA_WIDTH * TOKEN_DIM;
  localparam int CNT_W = $clog2(TOKEN_NUM);
  localparam int LVL_W = $clog2(TOKEN_NUM + 1);
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(TOKEN_NUM - 1);

  logic [ROW_W-1:0] q_mem [2][TOKEN_NUM];
  logic [ROW_W-1:0] k_mem [2][TOKEN_NUM];
  logic [ROW_W-1:0] v_mem [2][TOKEN_NUM];

  logic             wr_bank;
  logic             rd_bank;
  logic [CNT_W-1:0] wr_row;
  logic [1:0]       full;

  logic accept;
  logic release_frame;

  // rst gates in_ready so no token can be taken while reset is held.
  assign in_ready      = !rst && !flush && !full[wr_bank];
  assign accept        = in_valid && in_ready;
  assign out_valid     = full[rd_bank];
  assign release_frame = out_valid && out_ready;
  assign fill_level    = full[wr_bank] ? LVL_W'(TOKEN_NUM) : LVL_W'(wr_row);

  // Control state. A fill completing on the write bank and a release of the
  // read bank in the same cycle always touch different full[] bits, because
  // the write bank is never full while the read bank must be.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_row  <= '0;
      full    <= 2'b00;
    end else begin
      if (flush) begin
        wr_row <= '0;
      end else if (accept) begin
        if (wr_row == LAST_ROW) begin
          full[wr_bank] <= 1'b1;
          wr_bank       <= ~wr_bank;
          wr_row        <= '0;
        end else begin
          wr_row <= wr_row + 1'b1;
        end
      end
      if (release_frame) begin
        full[rd_bank] <= 1'b0;
        rd_bank       <= ~rd_bank;
      end
    end
  end

  // Row storage. Cleared on reset so the outputs read as zero until the first
  // frame lands. Released banks keep their contents until overwritten.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < TOKEN_NUM; r++) begin
          q_mem[b][r] <= '0;
          k_mem[b][r] <= '0;
          v_mem[b][r] <= '0;
        end
      end
    end else if (accept) begin
      q_mem[wr_bank][wr_row] <= q_tok;
      k_mem[wr_bank][wr_row] <= k_tok;
      v_mem[wr_bank][wr_row] <= v_tok;
    end
  end

  // The output buses are a combinational view of the read bank. That bank
  // cannot be written while it is full, so the data holds until the release.
  always_comb begin
    Q_out = '0;
    K_out = '0;
    V_out = '0;
    for (int r = 0; r < TOKEN_NUM; r++) begin
      Q_out[ROW_W*r +: ROW_W] = q_mem[rd_bank][r];
      K_out[ROW_W*r +: ROW_W] = k_mem[rd_bank][r];
      V_out[ROW_W*r +: ROW_W] = v_mem[rd_bank][r];
    end
  end

endmodule

// File: tb/tb_qkv_token_buffer.sv
// Directed testbench for qkv_token_buffer.
// Token with id n carries element j = {n[3:0], j[3:0], 4'h0, n[7:4]} on q.
// The k element is that value plus 1, and the v element is that value plus 2.
// For ids 0..15 this reduces to 16'h{i}{j}00.
// A frame that starts at id s holds ids s..s+7 in rows 0..7.
module tb_qkv_token_buffer;

  localparam int DW    = 16;
  localparam int TD    = 4;
  localparam int TN    = 8;
  localparam int ROW_W = DW * TD;
  localparam int FLAT  = ROW_W * TN;
  localparam int LVL_W = $clog2(TN + 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [ROW_W-1:0] q_tok = '0;
  logic [ROW_W-1:0] k_tok = '0;
  logic [ROW_W-1:0] v_tok = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [FLAT-1:0]  Q_out, K_out, V_out;
  logic [LVL_W-1:0] fill_level;

  qkv_token_buffer #(.DATA_WIDTH(DW), .TOKEN_DIM(TD), .TOKEN_NUM(TN)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .q_tok(q_tok), .k_tok(k_tok), .v_tok(v_tok),
    .out_valid(out_valid), .out_ready(out_ready),
    .Q_out(Q_out), .K_out(K_out), .V_out(V_out),
    .fill_level(fill_level)
  );

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- reference data ----------------
  function automatic logic [DW-1:0] elem(input int id, input int j, input int which);
    logic [7:0] b;
    logic [3:0] jj;
    b  = id[7:0];
    jj = j[3:0];
    return {b[3:0], jj, 4'h0, b[7:4]} + DW'(which);
  endfunction

  function automatic logic [ROW_W-1:0] make_row(input int id, input int which);
    logic [ROW_W-1:0] r;
    r = '0;
    for (int j = 0; j < TD; j++) r[DW*j +: DW] = elem(id, j, which);
    return r;
  endfunction

  function automatic logic [FLAT-1:0] exp_mat(input int start, input int which);
    logic [FLAT-1:0] m;
    m = '0;
    for (int r = 0; r < TN; r++) m[ROW_W*r +: ROW_W] = make_row(start + r, which);
    return m;
  endfunction

  // ---------------- checkers ----------------
  task automatic check_bus(input string tag, input logic [FLAT-1:0] obs,
                           input logic [FLAT-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_frame(input string tag, input int start);
    check_bus({tag, "_q"}, Q_out, exp_mat(start, 0));
    check_bus({tag, "_k"}, K_out, exp_mat(start, 1));
    check_bus({tag, "_v"}, V_out, exp_mat(start, 2));
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_tok(input int id);
    q_tok    = make_row(id, 0);
    k_tok    = make_row(id, 1);
    v_tok    = make_row(id, 2);
    in_valid = 1'b1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    // Reset state
    #2;
    check_val("rst_in_ready", 32'(in_ready), 0);
    check_val("rst_out_valid", 32'(out_valid), 0);
    check_bus("rst_q_out", Q_out, '0);
    check_val("rst_fill", 32'(fill_level), 0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    check_val("post_rst_in_ready", 32'(in_ready), 1);

    // Basic frame, out_ready=1
    out_ready = 1'b1;
    for (int n = 0; n < TN; n++) begin
      drive_tok(n);
      #1;
      check_val("basic_in_ready", 32'(in_ready), 1);
      tick();
      check_val("basic_fill", 32'(fill_level), (n + 1) % TN);
      check_val("basic_out_valid", 32'(out_valid), (n == TN - 1) ? 1 : 0);
    end
    in_valid = 1'b0;
    check_frame("basic", 0);
    tick();
    check_val("basic_pulse_end", 32'(out_valid), 0);

    // Back-to-back streaming: ids 8..31, three frames
    for (int n = 0; n < 3 * TN; n++) begin
      drive_tok(8 + n);
      #1;
      check_val("stream_in_ready", 32'(in_ready), 1);
      tick();
      check_val("stream_out_valid", 32'(out_valid), ((n + 1) % TN == 0) ? 1 : 0);
      if ((n + 1) % TN == 0) check_frame("stream", 8 + n + 1 - TN);
    end
    in_valid = 1'b0;
    tick();
    check_val("stream_end", 32'(out_valid), 0);

    // Full backpressure: ids 32..47 with out_ready low
    out_ready = 1'b0;
    for (int n = 0; n < 2 * TN; n++) begin
      drive_tok(32 + n);
      #1;
      check_val("bp_in_ready", 32'(in_ready), 1);
      tick();
    end
    in_valid = 1'b0;
    #1;
    check_val("bp_stalled", 32'(in_ready), 0);
    check_val("bp_fill", 32'(fill_level), TN);
    check_val("bp_out_valid", 32'(out_valid), 1);
    check_frame("bp_frame1", 32);
    for (int c = 0; c < 3; c++) begin
      tick();
      check_bus("bp_hold_q", Q_out, exp_mat(32, 0));
      check_val("bp_hold_valid", 32'(out_valid), 1);
    end
    out_ready = 1'b1;
    #1;
    check_val("bp_ready_before", 32'(in_ready), 0);
    tick();
    out_ready = 1'b0;
    #1;
    check_val("bp_out_valid2", 32'(out_valid), 1);
    check_frame("bp_frame2", 40);
    check_val("bp_in_ready_back", 32'(in_ready), 1);
    check_val("bp_fill_after", 32'(fill_level), 0);

    // Simultaneous fill-complete and release
    for (int n = 0; n < TN - 1; n++) begin
      drive_tok(48 + n);
      tick();
    end
    check_val("sim_fill7", 32'(fill_level), TN - 1);
    check_frame("sim_hold", 40);
    drive_tok(48 + TN - 1);
    out_ready = 1'b1;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    check_val("sim_out_valid", 32'(out_valid), 1);
    check_frame("sim_frame", 48);
    check_val("sim_fill", 32'(fill_level), 0);
    check_val("sim_in_ready", 32'(in_ready), 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_val("sim_drained", 32'(out_valid), 0);

    // Flush after 5 tokens, then a full frame of ids 62..69
    for (int n = 0; n < 5; n++) begin
      drive_tok(56 + n);
      tick();
    end
    check_val("flush_fill5", 32'(fill_level), 5);
    drive_tok(61);
    flush = 1'b1;
    #1;
    check_val("flush_in_ready", 32'(in_ready), 0);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    check_val("flush_fill0", 32'(fill_level), 0);
    check_val("flush_no_frame", 32'(out_valid), 0);
    for (int n = 0; n < TN; n++) begin
      drive_tok(62 + n);
      tick();
    end
    in_valid = 1'b0;
    check_val("flush_out_valid", 32'(out_valid), 1);
    check_frame("flush_frame", 62);

    // Asynchronous reset with one bank full and 3 tokens pending
    for (int n = 0; n < 3; n++) begin
      drive_tok(70 + n);
      tick();
    end
    in_valid = 1'b0;
    check_val("rst_mid_fill3", 32'(fill_level), 3);
    #2;
    rst = 1'b1;
    #1;
    check_val("rst_mid_out_valid", 32'(out_valid), 0);
    check_bus("rst_mid_q", Q_out, '0);
    check_bus("rst_mid_v", V_out, '0);
    check_val("rst_mid_in_ready", 32'(in_ready), 0);
    check_val("rst_mid_fill", 32'(fill_level), 0);
    tick();
    rst = 1'b0;
    #1;
    check_val("rst_mid_release_ready", 32'(in_ready), 1);
    check_val("rst_mid_release_valid", 32'(out_valid), 0);
    out_ready = 1'b1;
    for (int n = 0; n < TN; n++) begin
      drive_tok(80 + n);
      tick();
      check_val("fresh_out_valid", 32'(out_valid), (n == TN - 1) ? 1 : 0);
    end
    in_valid = 1'b0;
    check_frame("fresh_frame", 80);
    tick();
    check_val("fresh_end", 32'(out_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
